// File: rtl/cmd_responder.sv
// cmd_responder: responder end of the 32-bit req/rsp command channel.
// Decodes custom-0 command words into configuration writes, read-backs and
// launch strobes for the processing engine. Every accepted command produces
// exactly one response beat. The configuration registers are exposed to the
// datapath through a combinational read port.
//
// Optional feature macro: CMD_RSP_READBACK_EN
//   defined   -> fn=10 READ returns the sign-extended register value
//   undefined -> fn=10 is rejected like a reserved function (no read mux)

module cmd_responder #(
  parameter logic [6:0] CFG_BASE = 7'h10,
  parameter int         CFG_NUM  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_vaild,
  output logic        req_ready,
  input  logic [31:0] r_in,
  output logic        rsp_vaild,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic [4:0]  cfg_raddr,
  output logic [15:0] cfg_rdata,
  input  logic        launch_busy,
  output logic        launch_pulse,
  output logic [4:0]  launch_id,
  output logic [15:0] launch_arg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WAITL = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  localparam logic [1:0] FN_WRITE  = 2'b00;
  localparam logic [1:0] FN_LAUNCH = 2'b01;
  localparam logic [1:0] FN_READ   = 2'b10;

  logic [1:0]  state;
  logic [31:0] cmd_word;
  logic [15:0] cfg [CFG_NUM];

  // Decoded fields of the latched command word.
  logic [6:0]  cmd_idx;
  logic [1:0]  cmd_fn;
  logic [15:0] cmd_imm;
  logic [6:0]  cmd_op;
  logic [7:0]  rel_full;
  logic [4:0]  cmd_rel;
  logic        in_window;
  logic        fn_ok;
  logic        cmd_err;
  logic        cfg_we;
  logic        fire;

  assign cmd_idx = cmd_word[31:25];
  assign cmd_fn  = cmd_word[24:23];
  assign cmd_imm = cmd_word[22:7];
  assign cmd_op  = cmd_word[6:0];

  // Widened by one bit so an index below the base cannot wrap into the window.
  assign rel_full  = {1'b0, cmd_idx} - {1'b0, CFG_BASE};
  assign in_window = ({1'b0, cmd_idx} >= {1'b0, CFG_BASE}) && (rel_full < 8'(CFG_NUM));
  assign cmd_rel   = rel_full[4:0];

`ifdef CMD_RSP_READBACK_EN
  assign fn_ok = (cmd_fn != 2'b11);
`else
  assign fn_ok = (cmd_fn == FN_WRITE) || (cmd_fn == FN_LAUNCH);
`endif

  assign cmd_err = (cmd_op != OP_CUSTOM0) || !in_window || !fn_ok;

  // A write lands on the EXEC->RESP edge, so it is visible from the RESP cycle.
  assign cfg_we = (state == ST_EXEC) && !cmd_err && (cmd_fn == FN_WRITE);

  // Launch fires straight out of EXEC when the engine is free, else from WAITL.
  assign fire = !launch_busy &&
                (((state == ST_EXEC) && !cmd_err && (cmd_fn == FN_LAUNCH)) ||
                 (state == ST_WAITL));

  // Ready is forced low while reset is held, so nothing is accepted during it.
  assign req_ready = (state == ST_IDLE) && !reset;
  assign rsp_vaild = (state == ST_RESP);

  // Datapath read port; indices past the populated window read as zero.
  assign cfg_rdata = ({27'b0, cfg_raddr} < 32'(CFG_NUM)) ? cfg[cfg_raddr] : 16'h0000;

  // Command sequencing: accept, execute, optionally wait for the engine, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_word <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_vaild) begin
            cmd_word <= r_in;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data <= '0;
          rsp_err  <= cmd_err;
          state    <= ST_RESP;
          if (!cmd_err) begin
            case (cmd_fn)
              FN_LAUNCH: if (launch_busy) state <= ST_WAITL;
`ifdef CMD_RSP_READBACK_EN
              FN_READ:   rsp_data <= {{16{cfg[cmd_rel][15]}}, cfg[cmd_rel]};
`endif
              default: ;
            endcase
          end
        end
        ST_WAITL: begin
          if (!launch_busy) state <= ST_RESP;
        end
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  // Launch strobe with its id/argument, registered so the pulse is one clean cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      launch_pulse <= 1'b0;
      launch_id    <= '0;
      launch_arg   <= '0;
    end else begin
      launch_pulse <= fire;
      if (fire) begin
        launch_id  <= cmd_rel;
        launch_arg <= cmd_imm;
      end
    end
  end

  // Configuration register file, cleared on reset and written by WRITE commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset on purpose: the datapath reads it
      // combinationally, so every entry must be a known zero after reset.
      for (int i = 0; i < CFG_NUM; i++) cfg[i] <= '0;
    end else if (cfg_we) begin
      cfg[cmd_rel] <= cmd_imm;
    end
  end

endmodule

// File: tb/tb_cmd_responder.sv
// tb_cmd_responder: self-checking bench for cmd_responder. Expected responses
// are queued when a command is issued and compared when the response beat
// is handshaked. Build with CMD_RSP_READBACK_EN to exercise the read-back path.

module tb_cmd_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_vaild;
  logic        req_ready;
  logic [31:0] r_in;
  logic        rsp_vaild;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [4:0]  cfg_raddr;
  logic [15:0] cfg_rdata;
  logic        launch_busy;
  logic        launch_pulse;
  logic [4:0]  launch_id;
  logic [15:0] launch_arg;

`ifdef CMD_RSP_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  localparam logic [6:0] OP = 7'b0001011;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb_q[$];
  rsp_t        exp_rsp;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pulse_cnt = 0;
  logic [15:0] model_cfg [32];

  cmd_responder dut (
    .clk         (clk),
    .reset       (reset),
    .req_vaild   (req_vaild),
    .req_ready   (req_ready),
    .r_in        (r_in),
    .rsp_vaild   (rsp_vaild),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .cfg_raddr   (cfg_raddr),
    .cfg_rdata   (cfg_rdata),
    .launch_busy (launch_busy),
    .launch_pulse(launch_pulse),
    .launch_id   (launch_id),
    .launch_arg  (launch_arg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] idx, input logic [1:0] fn,
                                     input logic [15:0] imm);
    return {idx, fn, imm, OP};
  endfunction

  // Move to just after the next rising edge before touching inputs.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one command, queue its expected response, return in the EXEC cycle.
  task automatic send(input logic [31:0] word, input logic [31:0] exp_data, input logic exp_err);
    bit ok;
    ok = 1'b0;
    step();
    sb_q.push_back({exp_err, exp_data});
    req_vaild = 1'b1;
    r_in      = word;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    step();
    req_vaild = 1'b0;
    r_in      = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready && !rsp_vaild) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard consumer and launch pulse counter.
  always @(negedge clk) begin
    if (launch_pulse) pulse_cnt++;
    if (!reset && rsp_vaild && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_rsp = sb_q.pop_front();
        check("rsp_data", rsp_data, exp_rsp.data);
        check("rsp_err", 32'(rsp_err), 32'(exp_rsp.err));
      end
    end
  end

  initial begin
    int p0;
    int bad;
    logic [31:0] err_words [5];

    reset       = 1'b1;
    req_vaild   = 1'b0;
    r_in        = '0;
    rsp_ready   = 1'b1;
    launch_busy = 1'b0;
    cfg_raddr   = '0;
    for (int a = 0; a < 32; a++) model_cfg[a] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_vaild", 32'(rsp_vaild), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_pulse", 32'(launch_pulse), 32'd0);
    check("rst_launch_id", 32'(launch_id), 32'd0);
    check("rst_launch_arg", 32'(launch_arg), 32'd0);
    step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 32'd1);

    // Basic WRITE with latency and visibility on the read port
    cfg_raddr = 5'd0;
    send(32'h2000010B, 32'd0, 1'b0);
    model_cfg[0] = 16'h0002;
    @(negedge clk);
    check("t1_exec_no_rsp", 32'(rsp_vaild), 32'd0);
    check("t1_cfg_before", 32'(cfg_rdata), 32'd0);
    @(negedge clk);
    check("t1_rsp_vaild", 32'(rsp_vaild), 32'd1);
    check("t1_busy_ready", 32'(req_ready), 32'd0);
    check("t1_cfg_rdata", 32'(cfg_rdata), 32'h0002);
    wait_idle();

    // WRITE then immediate READ (negative value), plus a positive READ
    send(32'h267FFF0B, 32'd0, 1'b0);
    model_cfg[3] = 16'hFFFE;
    wait_idle();
    send(32'h2700000B, RB ? 32'hFFFFFFFE : 32'd0, !RB);
    wait_idle();
    send(mk(7'h10, 2'b10, 16'h0000), RB ? 32'h00000002 : 32'd0, !RB);
    wait_idle();
    cfg_raddr = 5'd3;
    #1;
    check("t2_cfg_rdata", 32'(cfg_rdata), 32'h0000FFFE);

    // LAUNCH with engine free: pulse registered out of EXEC
    launch_busy = 1'b0;
    p0 = pulse_cnt;
    send(mk(7'h10, 2'b01, 16'h0005), 32'd0, 1'b0);
    @(negedge clk);
    check("t3_free_early", 32'(launch_pulse), 32'd0);
    @(negedge clk);
    check("t3_free_pulse", 32'(launch_pulse), 32'd1);
    check("t3_free_id", 32'(launch_id), 32'd0);
    check("t3_free_arg", 32'(launch_arg), 32'h0005);
    wait_idle();
    check("t3_free_count", 32'(pulse_cnt - p0), 32'd1);

    // LAUNCH held off by busy for 10 cycles
    launch_busy = 1'b1;
    p0 = pulse_cnt;
    send(32'h3C81000B, 32'd0, 1'b0);
    repeat (10) @(negedge clk);
    check("t3_busy_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("t3_busy_no_rsp", 32'(rsp_vaild), 32'd0);
    step();
    launch_busy = 1'b0;
    @(negedge clk);
    check("t3_release_early", 32'(launch_pulse), 32'd0);
    @(negedge clk);
    check("t3_release_pulse", 32'(launch_pulse), 32'd1);
    check("t3_release_id", 32'(launch_id), 32'd14);
    check("t3_release_arg", 32'(launch_arg), 32'h0200);
    wait_idle();
    check("t3_release_count", 32'(pulse_cnt - p0), 32'd1);

    // Rejected commands: bad opcode, idx above/below window, reserved fn
    err_words[0] = 32'h20000133;
    err_words[1] = mk(7'h7F, 2'b00, 16'h1234);
    err_words[2] = mk(7'h0F, 2'b00, 16'h0001);
    err_words[3] = mk(7'h30, 2'b00, 16'h0001);
    err_words[4] = mk(7'h11, 2'b11, 16'h0007);
    for (int k = 0; k < 5; k++) begin
      send(err_words[k], 32'd0, 1'b1);
      wait_idle();
    end
    // Last register of the window is writable
    send(mk(7'h2F, 2'b00, 16'hABCD), 32'd0, 1'b0);
    model_cfg[31] = 16'hABCD;
    wait_idle();
    for (int a = 0; a < 32; a++) begin
      cfg_raddr = 5'(a);
      #1;
      check($sformatf("t4_cfg_%0d", a), 32'(cfg_rdata), 32'(model_cfg[a]));
    end

    // Back-pressure: response held, second request not accepted
    rsp_ready = 1'b0;
    send(mk(7'h11, 2'b00, 16'h0055), 32'd0, 1'b0);
    model_cfg[1] = 16'h0055;
    req_vaild = 1'b1;
    r_in      = mk(7'h12, 2'b00, 16'h0077);
    @(negedge clk);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_vaild || req_ready) bad++;
    end
    check("t5_hold", 32'(bad), 32'd0);
    step();
    req_vaild = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    check("t5_no_second", 32'(sb_q.size()), 32'd0);
    cfg_raddr = 5'd2;
    #1;
    check("t5_cfg2_untouched", 32'(cfg_rdata), 32'd0);
    cfg_raddr = 5'd1;
    #1;
    check("t5_cfg1", 32'(cfg_rdata), 32'h0055);

    // Reset while waiting on a busy engine aborts the command
    launch_busy = 1'b1;
    p0 = pulse_cnt;
    send(32'h3C81000B, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    step();
    reset       = 1'b1;
    launch_busy = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    check("t6_rst_rsp", 32'(rsp_vaild), 32'd0);
    step();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_ready_after", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("t6_no_rsp", 32'(rsp_vaild), 32'd0);
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      cfg_raddr = 5'(a);
      #1;
      if (cfg_rdata !== 16'h0000) bad++;
    end
    check("t6_cfg_cleared", 32'(bad), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
